// File: rtl/game_pkg.sv
// Shared definitions for the sprite movers: screen geometry, colours and
// the step-engine state encoding.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        INIT_DRAW,
        ERASE,
        UPDATE,
        DRAW
    } state_t;

endpackage

// File: rtl/zero_edge_detect.sv
// Turns the arrival of a down-counter at zero into a single-cycle tick,
// qualified by enable.
module zero_edge_detect #(
    parameter int CNT_W = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] count,
    output logic             tick
);

    logic zero;
    logic zero_d;

    assign zero = (count == '0);
    assign tick = enable & zero & ~zero_d;

    // Frozen while disabled so a zero that arrives with enable low
    // still ticks on the first enabled cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            zero_d <= 1'b1;
        end else if (enable) begin
            zero_d <= zero;
        end
    end

endmodule

// File: rtl/sprite_step_engine.sv
// Erase / move-down / redraw engine for a square sprite, one pixel per
// cycle toward the VGA adapter, advanced by rate-divider zero ticks.
module sprite_step_engine
    import game_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int SPR_LOG = 2,
    parameter int X_POS   = 76,
    parameter int Y_START = 0,
    parameter int Y_LIMIT = 116
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [27:0]         rd_count,
    input  logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                busy,
    output logic                overrun
);

    localparam int PIX_W = 2 * SPR_LOG;

    state_t              state, state_n;
    logic [PIX_W-1:0]    pix, pix_n;
    logic [Y_W-1:0]      y_pos, y_n;
    logic [COLOUR_W-1:0] draw_col, col_n;
    logic                pending, pend_n;
    logic                ovr_n;
    logic                tick;
    logic                plot_n;
    logic [X_W-1:0]      x_n;
    logic [Y_W-1:0]      yo_n;
    logic [COLOUR_W-1:0] co_n;

    zero_edge_detect #(
        .CNT_W (28)
    ) u_zero (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .count  (rd_count),
        .tick   (tick)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        pix_n   = pix + 1'b1;
        y_n     = y_pos;
        col_n   = draw_col;
        pend_n  = pending;
        ovr_n   = overrun;

        if (state != IDLE && tick) begin
            if (pending) ovr_n = 1'b1;
            else         pend_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                pix_n = '0;
                if (tick || pending) begin
                    state_n = ERASE;
                    pend_n  = pending & tick;
                end
            end
            // One set-up cycle after reset to latch the colour.
            INIT_DRAW: begin
                pix_n   = '0;
                col_n   = colour;
                state_n = DRAW;
            end
            ERASE: begin
                if (&pix) state_n = UPDATE;
            end
            UPDATE: begin
                pix_n   = '0;
                col_n   = colour;
                state_n = DRAW;
                if (y_pos == Y_W'(Y_LIMIT)) y_n = Y_W'(Y_START);
                else                        y_n = y_pos + 1'b1;
            end
            DRAW: begin
                if (&pix) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-cycle pixel so the first
    // erase pixel appears the cycle after the tick edge.
    always_comb begin
        plot_n = (state_n == ERASE) || (state_n == DRAW);
        co_n   = (state_n == ERASE) ? COL_BLACK : col_n;
        x_n    = X_W'(X_POS) + X_W'(pix_n[SPR_LOG-1:0]);
        yo_n   = y_n + Y_W'(pix_n[PIX_W-1:SPR_LOG]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INIT_DRAW;
            pix        <= '0;
            y_pos      <= Y_W'(Y_START);
            draw_col   <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            state      <= state_n;
            pix        <= pix_n;
            y_pos      <= y_n;
            draw_col   <= col_n;
            pending    <= pend_n;
            overrun    <= ovr_n;
            plot       <= plot_n;
            x_out      <= x_n;
            y_out      <= yo_n;
            colour_out <= co_n;
        end
    end

endmodule
